// File: rtl/jk_bank_driver.sv
// Command-side driver for an external bank of JK flip-flops: accepts a target word,
// drives hold-biased J/K excitations, verifies Q feedback and re-drives on mismatch.
module jk_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 1
) (
  input  logic                       Clk_In,
  input  logic                       Reset_In,
  input  logic                       Target_Valid_In,
  output logic                       Target_Ready_Out,
  input  logic [WIDTH-1:0]           Target_Data_In,
  input  logic [WIDTH-1:0]           Q_In,
  output logic [WIDTH-1:0]           J_Out,
  output logic [WIDTH-1:0]           K_Out,
  output logic                       Done_Out,
  output logic                       Error_Out,
  output logic [$clog2(WIDTH+1)-1:0] Changed_Count_Out,
  output logic [7:0]                 Error_Count_Out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] target;
  logic [RW-1:0]    retry_left;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CW'(v[i]);
    end
    return cnt;
  endfunction

  // Hold-biased excitation: only bits that must change get J or K, never both.
  function automatic logic [WIDTH-1:0] set_mask(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] t);
    return ~q & t;
  endfunction

  function automatic logic [WIDTH-1:0] clr_mask(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] t);
    return q & ~t;
  endfunction

  // NOTE: every register below is assigned with <= so all updates take the
  // pre-edge values; blocking here would let later statements see new state.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state             <= IDLE;
      Target_Ready_Out  <= 1'b1;
      J_Out             <= '0;
      K_Out             <= '0;
      Done_Out          <= 1'b0;
      Error_Out         <= 1'b0;
      Changed_Count_Out <= '0;
      Error_Count_Out   <= '0;
      target            <= '0;
      retry_left        <= '0;
    end else begin
      Done_Out  <= 1'b0;
      Error_Out <= 1'b0;
      case (state)
        IDLE: begin
          J_Out <= '0;
          K_Out <= '0;
          if (Target_Valid_In && Target_Ready_Out) begin
            target            <= Target_Data_In;
            J_Out             <= set_mask(Q_In, Target_Data_In);
            K_Out             <= clr_mask(Q_In, Target_Data_In);
            Changed_Count_Out <= popcount(Q_In ^ Target_Data_In);
            retry_left        <= RW'(MAX_RETRY);
            Target_Ready_Out  <= 1'b0;
            state             <= DRIVE;
          end
        end

        // The bank samples J/K on this edge; release them so it holds afterwards.
        DRIVE: begin
          J_Out <= '0;
          K_Out <= '0;
          state <= CHECK;
        end

        CHECK: begin
          J_Out <= '0;
          K_Out <= '0;
          if (Q_In == target) begin
            Done_Out         <= 1'b1;
            Target_Ready_Out <= 1'b1;
            state            <= IDLE;
          end else if (retry_left != '0) begin
            retry_left <= retry_left - 1'b1;
            J_Out      <= set_mask(Q_In, target);
            K_Out      <= clr_mask(Q_In, target);
            state      <= DRIVE;
          end else begin
            Done_Out         <= 1'b1;
            Error_Out        <= 1'b1;
            Target_Ready_Out <= 1'b1;
            if (Error_Count_Out != 8'hFF) begin
              Error_Count_Out <= Error_Count_Out + 8'd1;
            end
            state <= IDLE;
          end
        end

        default: begin
          J_Out            <= '0;
          K_Out            <= '0;
          Target_Ready_Out <= 1'b1;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule
